// File: rtl/instr_encoder.sv
// Instruction encoder: packs opcode, register fields and a narrowed immediate/target
// into a 32-bit word, range-checks the narrowing, and buffers results in a FIFO.
module instr_encoder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_op,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_shamt,
  input  logic [4:0]               in_aluop,
  input  logic [31:0]              in_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_word,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               err_count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [AddrW:0] FullCnt = (AddrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

  state_e             state_q;
  logic [AddrW-1:0]   wr_ptr_q;
  logic [AddrW-1:0]   rd_ptr_q;
  logic [AddrW:0]     count_q;
  logic [7:0]         err_count_q;
  logic [31:0]        mem_word_q [DEPTH];
  logic [DEPTH-1:0]   mem_err_q;

  logic [31:0]        enc_word;
  logic               enc_err;
  logic               push;
  logic               pop;

  // Format is chosen by opcode; out-of-range values are truncated but flagged.
  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    if (in_op == 5'd0) begin
      enc_word = {in_op, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
    end else if (in_op == 5'd1 || in_op == 5'd21 || in_op == 5'd22) begin
      enc_word = {in_op, in_value[26:0]};
      enc_err  = (in_value[31:27] != {5{in_value[26]}});
    end else begin
      enc_word = {in_op, in_rd, in_rs, in_value[16:0]};
      enc_err  = (in_value[31:17] != {15{in_value[16]}});
    end
  end

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      if (push && enc_err && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 1'b1;
      case (state_q)
        StEmpty: begin
          if (push) state_q <= StPartial;
        end
        StPartial: begin
          if (push && !pop && (count_q == FullCnt - 1'b1)) begin
            state_q <= StFull;
          end else if (pop && !push && (count_q == 1)) begin
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (pop) state_q <= StPartial;
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  // Storage needs no reset: occupancy state alone decides what is visible.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_word_q[wr_ptr_q] <= enc_word;
      mem_err_q[wr_ptr_q]  <= enc_err;
    end
  end

  assign out_word  = out_valid ? mem_word_q[rd_ptr_q] : 32'h0;
  assign out_err   = out_valid ? mem_err_q[rd_ptr_q] : 1'b0;
  assign count     = count_q;
  assign err_count = err_count_q;

endmodule
